vdn_pipe: RTL and testbench

VDN_PIPE -- requirements
Module: vdn_pipe

---
 rtl/vdn_pkg.sv | 20 ++
 rtl/vdn_slice.sv | 23 ++
 rtl/vdn_pipe.sv | 171 +++++++++++++++++
 tb/tb_vdn_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdn_pkg.sv
// Shared definitions for the vdn_pipe sliced adder: default geometry,
// the slice-width helper and the per-stage control record.
package vdn_pkg;

    localparam int VDN_WIDTH_DEF  = 16;
    localparam int VDN_STAGES_DEF = 4;

    // Bits handled by each pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Control carried by every stage register: beat present, carry out of
    // the slice that stage has just finished.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/vdn_slice.sv
// vdn_slice: combinational N-bit adder slice. Besides the sum and carry out
// it exposes the carry into the slice MSB so the last stage can form the
// signed overflow flag.
module vdn_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [N:0] sum_ext;

    // Plain add; the carry into the MSB is recovered from the MSB sum bit.
    assign sum_ext = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    assign s       = sum_ext[N-1:0];
    assign co      = sum_ext[N];
    assign c_msb   = a[N-1] ^ b[N-1] ^ sum_ext[N-1];

endmodule

// File: rtl/vdn_pipe.sv
// vdn_pipe: add/subtract pipelined over STAGES slices of WIDTH/STAGES bits.
// Stage k adds slice k of the beat it receives and registers the carry for
// stage k+1; unconsumed operand slices and finished sum slices travel along
// with the beat. A beat presented in cycle c shows out_valid in cycle
// c+STAGES when the output is not stalled.
//
// Handshake: a beat moves on an edge where valid && ready. One global enable
// adv = !out_valid || out_ready moves every stage at once; in_ready == adv,
// and when adv is low every register (including s/cout/ovf) holds.
//
// Build option: define VDN_PIPE_OVF_EN to register a signed-overflow flag
// with the beat in the final stage; without it ovf is tied low.
module vdn_pipe
    import vdn_pkg::*;
#(
    parameter int WIDTH  = VDN_WIDTH_DEF,
    parameter int STAGES = VDN_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = slice_width(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("vdn_pipe: WIDTH must be divisible by STAGES");
    end
    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("vdn_pipe: WIDTH must be in 4..64");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    stage_ctl_t       ctl_q   [STAGES];
    stage_ctl_t       ctl_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];

    // What each stage sees on its input side.
    logic             stg_in_valid [STAGES];
    logic [WIDTH-1:0] src_a        [STAGES];
    logic [WIDTH-1:0] src_b        [STAGES];
    logic [WIDTH-1:0] src_sum      [STAGES];

    logic [SW-1:0]    sl_a  [STAGES];
    logic [SW-1:0]    sl_b  [STAGES];
    logic [SW-1:0]    sl_s  [STAGES];
    logic             sl_ci [STAGES];
    logic             sl_co [STAGES];
    logic [STAGES-1:0] sl_cm;
    logic             unused_cm;

    assign adv       = !ctl_q[STAGES-1].valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = ctl_q[STAGES-1].valid;
    assign s         = sum_q[STAGES-1];
    assign cout      = ctl_q[STAGES-1].carry;

    // Subtraction is a + ~b + 1; the +1 enters as the stage-0 carry.
    assign b_eff     = sub ? ~b : b;
    assign unused_cm = ^sl_cm;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stg_in_valid[k] = in_valid;
            assign src_a[k]        = a;
            assign src_b[k]        = b_eff;
            assign src_sum[k]      = '0;
            assign sl_ci[k]        = sub ? 1'b1 : cin;
        end else begin : g_body
            assign stg_in_valid[k] = ctl_q[k-1].valid;
            assign src_a[k]        = a_q[k-1];
            assign src_b[k]        = b_q[k-1];
            assign src_sum[k]      = sum_q[k-1];
            assign sl_ci[k]        = ctl_q[k-1].carry;
        end

        assign sl_a[k] = src_a[k][k*SW +: SW];
        assign sl_b[k] = src_b[k][k*SW +: SW];

        vdn_slice #(.N(SW)) u_slice (
            .a     (sl_a[k]),
            .b     (sl_b[k]),
            .ci    (sl_ci[k]),
            .s     (sl_s[k]),
            .co    (sl_co[k]),
            .c_msb (sl_cm[k])
        );
    end

    // Next state: on adv every stage takes its predecessor; data only loads
    // behind a valid beat so s stays on the last result across bubbles.
    always_comb begin
        ctl_d = ctl_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_d[k].valid = stg_in_valid[k];
                if (stg_in_valid[k]) begin
                    ctl_d[k].carry         = sl_co[k];
                    a_d[k]                 = src_a[k];
                    b_d[k]                 = src_b[k];
                    sum_d[k]               = src_sum[k];
                    sum_d[k][k*SW +: SW]   = sl_s[k];
                end
            end
        end
    end

    // Stage registers; reset drops every in-flight beat immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            ctl_q <= ctl_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
        end
    end

`ifdef VDN_PIPE_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Overflow = carry into MSB xor carry out of MSB, captured with the beat.
    always_comb begin
        ovf_d = ovf_q;
        if (adv && stg_in_valid[STAGES-1]) begin
            ovf_d = sl_cm[STAGES-1] ^ sl_co[STAGES-1];
        end
    end

    // Overflow flag register, held and reset with the final stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_vdn_pipe.sv
// Bench for vdn_pipe: three builds (16/4, 32/2, 8/8) share one stimulus
// stream; each has its own expected queue filled from an arithmetic model.
module tb_vdn_pipe;

`ifdef VDN_PIPE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a_drv = '0;
  logic [63:0] b_drv = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        in_ready_16, out_valid_16, cout_16, ovf_16;
  logic [15:0] s_16;
  logic        in_ready_32, out_valid_32, cout_32, ovf_32;
  logic [31:0] s_32;
  logic        in_ready_8, out_valid_8, cout_8, ovf_8;
  logic [7:0]  s_8;

  int n_checks = 0;
  int n_fail   = 0;
  int pops16   = 0;

  logic [65:0] exp_q16[$];
  logic [65:0] exp_q32[$];
  logic [65:0] exp_q8[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vdn_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_16),
    .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_16), .out_ready(out_ready),
    .s(s_16), .cout(cout_16), .ovf(ovf_16)
  );

  vdn_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
    .a(a_drv[31:0]), .b(b_drv[31:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_32), .out_ready(out_ready),
    .s(s_32), .cout(cout_32), .ovf(ovf_32)
  );

  vdn_pipe #(.WIDTH(8), .STAGES(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_8), .out_ready(out_ready),
    .s(s_8), .cout(cout_8), .ovf(ovf_8)
  );

  task automatic chk(input string nm, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: {ovf, cout, s} from plain w-bit arithmetic.
  function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input logic ci,
                                        input logic sb);
    logic [63:0] mask, aa, bb, res;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = av & mask;
    bb   = (sb ? ~bv : bv) & mask;
    full = {1'b0, aa} + {1'b0, bb} + (sb ? 65'd1 : {64'd0, ci});
    res  = full[63:0] & mask;
    co   = full[w];
    ov   = OVF_ON && (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
    return {ov, co, res};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q16.delete();
      exp_q32.delete();
      exp_q8.delete();
    end else begin
      if (out_valid_16) begin
        if (exp_q16.size() == 0) chk("w16_unexpected", {65'd0, out_valid_16}, 66'd0);
        else begin
          chk("w16_result", {ovf_16, cout_16, 48'd0, s_16}, exp_q16[0]);
          if (out_ready) begin
            void'(exp_q16.pop_front());
            pops16++;
          end
        end
      end
      if (out_valid_32) begin
        if (exp_q32.size() == 0) chk("w32_unexpected", {65'd0, out_valid_32}, 66'd0);
        else begin
          chk("w32_result", {ovf_32, cout_32, 32'd0, s_32}, exp_q32[0]);
          if (out_ready) void'(exp_q32.pop_front());
        end
      end
      if (out_valid_8) begin
        if (exp_q8.size() == 0) chk("w8_unexpected", {65'd0, out_valid_8}, 66'd0);
        else begin
          chk("w8_result", {ovf_8, cout_8, 56'd0, s_8}, exp_q8[0]);
          if (out_ready) void'(exp_q8.pop_front());
        end
      end
      if (in_valid && in_ready_16) exp_q16.push_back(model(16, a_drv, b_drv, cin, sub));
      if (in_valid && in_ready_32) exp_q32.push_back(model(32, a_drv, b_drv, cin, sub));
      if (in_valid && in_ready_8)  exp_q8.push_back(model(8, a_drv, b_drv, cin, sub));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input logic sb,
                          output logic [17:0] r16, output int l16,
                          output int l32, output int l8);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_drv = av; b_drv = bv; cin = ci; sub = sb;
    r16 = '0; l16 = 0; l32 = 0; l8 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      if (out_valid_16 && l16 == 0) begin
        l16 = c;
        r16 = {ovf_16, cout_16, s_16};
      end
      if (out_valid_32 && l32 == 0) l32 = c;
      if (out_valid_8 && l8 == 0) l8 = c;
    end
  endtask

  task automatic directed(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, input logic [17:0] exp16);
    logic [17:0] r16;
    int l16, l32, l8;
    send_one({48'd0, av}, {48'd0, bv}, ci, sb, r16, l16, l32, l8);
    chk({nm, "_result"}, {48'd0, r16}, {48'd0, exp16});
    chk({nm, "_lat16"}, 66'(l16), 66'd4);
    chk({nm, "_lat32"}, 66'(l32), 66'd2);
    chk({nm, "_lat8"},  66'(l8),  66'd8);
  endtask

  task automatic stall_test();
    int  sent;
    int  base;
    logic acc;
    sent = 0;
    acc  = 1'b0;
    base = pops16;
    for (int cyc = 0; cyc < 60 && (sent < 8 || pops16 - base < 8); cyc++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid  = (sent < 8);
      a_drv = {48'd0, 16'h1111 * 16'(sent + 1)};
      b_drv = {48'd0, 16'h0F0F + 16'h1010 * 16'(sent)};
      cin   = sent[1];
      sub   = sent[0];
      @(negedge clk);
      acc = in_valid && in_ready_16;
      if (cyc >= 6 && cyc < 9) begin
        chk("stall_in_ready", {65'd0, in_ready_16}, 66'd0);
        chk("stall_out_valid", {65'd0, out_valid_16}, 66'd1);
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_beats_out", 66'(pops16 - base), 66'd8);
  endtask

  task automatic reset_test();
    logic [17:0] r16;
    int  l16, l32, l8;
    int  seen;
    int  stale;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a_drv = 64'h0000_0000_0000_2000 + 64'(i);
      b_drv = 64'h0000_0000_0000_0100;
      cin = 1'b0; sub = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (out_valid_16) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("rst_pre_out_valid", 66'(seen), 66'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", {65'd0, out_valid_16}, 66'd0);
    chk("rst_async_s", {48'd0, ovf_16, cout_16, s_16}, 66'd0);
    chk("rst_async_in_ready", {65'd0, in_ready_16}, 66'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid_16 || out_valid_32 || out_valid_8) stale++;
    end
    chk("rst_no_stale", 66'(stale), 66'd0);
    send_one(64'h0F0F, 64'h0101, 1'b0, 1'b0, r16, l16, l32, l8);
    chk("post_rst_result", {48'd0, r16}, {48'd0, 2'b00, 16'h1010});
    chk("post_rst_lat16", 66'(l16), 66'd4);
  endtask

  task automatic random_phase();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a_drv = {$urandom, $urandom};
      b_drv = {$urandom, $urandom};
      cin   = 1'($urandom_range(0, 1));
      sub   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_q16", 66'(exp_q16.size()), 66'd0);
    chk("drain_q32", 66'(exp_q32.size()), 66'd0);
    chk("drain_q8",  66'(exp_q8.size()),  66'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {65'd0, out_valid_16}, 66'd0);
    chk("reset_s", {48'd0, ovf_16, cout_16, s_16}, 66'd0);
    chk("reset_in_ready", {65'd0, in_ready_16}, 66'd1);
    rst = 1'b0;

    directed("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, {2'b00, 16'h5555});
    directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h0000});
    directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {OVF_ON, 1'b0, 16'h8000});
    directed("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, {2'b00, 16'hFFFE});
    directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, {OVF_ON, 1'b1, 16'h7FFF});
    directed("add_cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, {2'b00, 16'h0100});

    stall_test();
    reset_test();
    random_phase();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
